// File: rtl/arcade_bus_pkg.sv
// arcade_bus_pkg: shared types and constants for the arcade core's ROM bus arbitration
package arcade_bus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;
  localparam logic REQ_M68K = 1'b0;
  localparam logic REQ_Z80 = 1'b1;
  localparam logic [22:0] Z80_BASE_DEF = 23'h040000;
endpackage

// File: rtl/rom_bus_arbiter_if.sv
// rom_bus_arbiter_if: level req / one-cycle ack word-wide ROM port
interface rom_bus_arbiter_if #(parameter int AW = 23);
  logic req;
  logic [AW-1:0] addr;
  logic ack;
  logic [15:0] data;
  modport master (output req, addr, input ack, data);
  modport slave (input req, addr, output ack, data);
endinterface

// File: rtl/rise_edge_det.sv
// rise_edge_det: registered copy of a select plus its rising-edge pulse
module rise_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else q <= d;
  end
  assign rise = d & ~q;
endmodule

// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter: round-robin sharing of one ROM port between the 68000 and the Z80
module rom_bus_arbiter import arcade_bus_pkg::*; #(
  parameter int ROM_AW = 23,
  parameter logic [ROM_AW-1:0] Z80_BASE = ROM_AW'(Z80_BASE_DEF)
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic m68k_rom_cs,
  input  logic [23:0] m68k_a,
  output logic m68k_dtack_n,
  output logic [15:0] m68k_rom_dout,
  input  logic z80_rom_cs,
  input  logic [15:0] z80_addr,
  output logic z80_wait_n,
  output logic [7:0] z80_rom_dout,
  rom_bus_arbiter_if.master rom
);
  state_t state, state_n;
  logic m_rise, z_rise, m_pend, z_pend, m_done, z_done, m_done_n, z_done_n;
  logic gnt, last, wd, sel_hi, req, go, pick, gnt_cs, ack_ok, cap, m_cap, z_cap;
  logic [ROM_AW-1:0] addr_q;
  logic unused;
  assign unused = m68k_a[0];
  rise_edge_det u_m_edge (.clk(clk_sys), .rst(reset), .d(m68k_rom_cs), .rise(m_rise));
  rise_edge_det u_z_edge (.clk(clk_sys), .rst(reset), .d(z80_rom_cs), .rise(z_rise));
  assign go = state == IDLE && (m_pend || z_pend);
  assign pick = (m_pend && z_pend) ? ~last : (m_pend ? REQ_M68K : REQ_Z80);
  assign gnt_cs = gnt == REQ_Z80 ? z80_rom_cs : m68k_rom_cs;
  assign ack_ok = state == WAIT_ACK && rom.ack;
  // a grant whose select dropped at any point is finished on the bus but its data is dropped
  assign cap = ack_ok && !wd && gnt_cs;
  assign m_cap = cap && gnt == REQ_M68K;
  assign z_cap = cap && gnt == REQ_Z80;
  assign m_done_n = m68k_rom_cs && (m_done || m_cap);
  assign z_done_n = z80_rom_cs && (z_done || z_cap);
  assign z80_wait_n = !(z80_rom_cs && !z_done);
  assign rom.req = req;
  assign rom.addr = addr_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = go ? ISSUE : IDLE;
      ISSUE: state_n = WAIT_ACK;
      WAIT_ACK: state_n = rom.ack ? IDLE : WAIT_ACK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      req <= 1'b0;
      addr_q <= '0;
      m68k_rom_dout <= '0;
      z80_rom_dout <= '0;
      m_pend <= 1'b0;
      z_pend <= 1'b0;
      m_done <= 1'b0;
      z_done <= 1'b0;
      m68k_dtack_n <= 1'b1;
      last <= REQ_Z80;
      gnt <= REQ_M68K;
      wd <= 1'b0;
      sel_hi <= 1'b0;
    end else begin
      state <= state_n;
      req <= state_n != IDLE;
      // a fresh edge wins over the ack clear so a re-request during service is kept
      m_pend <= m68k_rom_cs && (m_rise || (m_pend && !m_cap));
      z_pend <= z80_rom_cs && (z_rise || (z_pend && !z_cap));
      m_done <= m_done_n;
      z_done <= z_done_n;
      m68k_dtack_n <= !m_done_n;
      if (go) begin
        gnt <= pick;
        wd <= 1'b0;
        sel_hi <= z80_addr[0];
        addr_q <= pick == REQ_Z80 ? Z80_BASE + ROM_AW'(z80_addr[15:1]) : ROM_AW'(m68k_a[23:1]);
      end else if (state != IDLE && !gnt_cs) wd <= 1'b1;
      if (ack_ok) last <= gnt;
      if (m_cap) m68k_rom_dout <= rom.data;
      if (z_cap) z80_rom_dout <= sel_hi ? rom.data[15:8] : rom.data[7:0];
    end
  end
endmodule

// File: doc/rom_bus_arbiter.md
Name: rom_bus_arbiter

Overview:
- Shares one word-wide program-ROM memory port between the 68000 and the Z80 sound CPU.
- Takes the decoded ROM chip selects and serializes the fetches onto a single req/ack memory interface.
- Returns read data and the bus-cycle handshakes to each CPU: DTACK_n to the 68000, WAIT_n to the Z80.
- Sits between the address decoder and the SDRAM/ROM controller in the top-level core.

Parameters:
ROM_AW, 23, word-address width of the shared ROM port
Z80_BASE, 23'h040000, word offset of the Z80 program inside the shared ROM (byte 0x080000)

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
m68k_rom_cs  in  1  decoded 68000 ROM select (already qualified by AS_n)
m68k_a  in  24  68000 byte address; bit 0 unused
m68k_dtack_n  out  1  data acknowledge to the 68000, active low
m68k_rom_dout  out  16  word returned to the 68000
z80_rom_cs  in  1  decoded Z80 ROM select (already qualified by MREQ_n)
z80_addr  in  16  Z80 byte address
z80_wait_n  out  1  wait request to the Z80, active low
z80_rom_dout  out  8  byte returned to the Z80
rom_req  out  1  memory request; level, held until ack
rom_addr  out  ROM_AW  memory word address
rom_ack  in  1  one-cycle pulse; rom_data valid in the same cycle
rom_data  in  16  memory read data

Behaviour:
- Reset values: m68k_dtack_n=1, rom_req=0, rom_addr=0, both dout=0, state=IDLE, pending and done flags=0, last_grant=Z80. Reset has priority over every other event. An in-flight transaction is abandoned; a later rom_ack is ignored in IDLE.
- Request capture: a registered copy of each cs is kept. A rising edge of a cs sets that CPU's pending flag on the next clock. If cs falls, pending and done are cleared.
- FSM states: IDLE, ISSUE, WAIT_ACK.
- IDLE -> ISSUE when any pending flag is set and no grant is active.
  - Both pending: grant the CPU not in last_grant (round-robin); first contention after reset goes to the 68000.
  - Grant latches requester id and address. rom_addr = m68k_a[23:1] for the 68000, or Z80_BASE + z80_addr[15:1] for the Z80.
- ISSUE: drive rom_req=1, go to WAIT_ACK. Minimum latency from cs edge to rom_req is 2 clocks.
- WAIT_ACK: hold rom_req and rom_addr stable. On rom_ack:
  - deassert rom_req in the next cycle;
  - capture data into the granted CPU's dout;
  - set that CPU's done flag, clear its pending flag;
  - update last_grant;
  - return to IDLE.
- Z80 byte select: z80_addr[0]=0 -> rom_data[7:0]; 1 -> rom_data[15:8].
- m68k_dtack_n is registered. It goes low the cycle after rom_ack when the 68000 was granted, and stays low while m68k_rom_cs=1. It returns high on the first clock after m68k_rom_cs falls.
- z80_wait_n is combinational: !(z80_rom_cs && !z80_done). The Z80 is held from the first cycle of cs until the cycle after its ack.
- Withdrawal before grant: pending is cleared and no memory cycle is issued.
- Withdrawal after grant: the memory transaction completes, data and done are discarded (not captured), and last_grant still updates.
- A new rising edge of cs for the CPU in service is captured as pending and served after the current grant.
- rom_ack in ISSUE is impossible by protocol and is ignored. rom_ack in IDLE is ignored.
- dout registers hold their value between accesses.

Decomposition:
- Shared package arcade_bus_pkg:
  - FSM state enum (IDLE/ISSUE/WAIT_ACK);
  - requester id constants (REQ_M68K=0, REQ_Z80=1);
  - default Z80_BASE constant.
- One natural sub-module, rise_edge_det: registered cs plus rising-edge pulse, instantiated once per requester.
- Arbitration and FSM stay in this module.

Test Plan:
- 68000 alone: m68k_rom_cs rises with m68k_a=24'h000124; memory acks 3 cycles after rom_req with 16'hBEEF -> rom_addr=23'h000092, m68k_rom_dout=16'hBEEF, m68k_dtack_n low the cycle after ack, high one clock after cs falls.
- Z80 odd byte: z80_addr=16'h1235, rom_data=16'hA55A -> rom_addr=23'h04091A, z80_rom_dout=8'hA5, z80_wait_n low from cs rise until the cycle after ack.
- Simultaneous edges right after reset -> 68000 served first, Z80 second. A repeat tie on the next pair goes to the 68000 again (last_grant=Z80 after the second service).
- Z80 withdraws cs before grant while the 68000 is in service -> only one rom_req pulse is issued and z80_rom_dout is unchanged.
- Reset asserted in WAIT_ACK, then a stray rom_ack -> rom_req=0 and m68k_dtack_n=1 on the cycle after reset, the ack is ignored, and the FSM stays in IDLE.
- 68000 drops cs after issue -> the transaction completes, m68k_dtack_n stays 1, and m68k_rom_dout keeps its old value.
